data_mem_access_unit: RTL and testbench
=======================================

Name: data_mem_access_unit

Overview:
- Memory-side responder for the data-memory enables produced by the single-cycle control decoder.
- Turns a load/store request (enables, funct3, byte address, store data) into one or two aligned 64-bit transactions on a req/ready data-memory port. Misaligned accesses are split across two doublewords.
- Returns sign/zero-extended load data to the regfile write mux.
- Stalls the core (`stall` gates PC write) until the access completes.

Parameters:
- MEM_ADDR_WIDTH, 61, width of the doubleword index on `mem_addr`; equals byte-address bits [63:3].

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- data_mem_read_en  in  1  load request from control
- data_mem_write_en  in  1  store request from control
- inst_funct3  in  3  access size/sign (RV64I load/store encoding)
- address  in  64  byte address from ALU
- store_data  in  64  rs2 data, LSB-justified
- load_data  out  64  extended load result
- stall  out  1  high while access is pending; core holds PC and the instruction
- mem_req  out  1  transaction request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  MEM_ADDR_WIDTH  doubleword index
- mem_byte_en  out  8  byte lane enables
- mem_wdata  out  64  lane-aligned write data
- mem_ready  in  1  one-cycle pulse: transaction complete; mem_rdata valid this cycle
- mem_rdata  in  64  read data

Behaviour:
- Reset (`reset_n` low, asynchronous): state IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_byte_en`, `mem_wdata`, `load_data` all 0.
  - `stall` forced 0 while `reset_n` is low.
- Size: funct3[1:0] → 1, 2, 4 or 8 bytes. offset = address[2:0]. Split when offset + size > 8.
- Load extension: 000 LB, 001 LH, 010 LW, 011 LD sign-extend. 100 LBU, 101 LHU, 110 LWU zero-extend. 111 is treated as LD. Stores use funct3[1:0] only.
- Both enables high: treated as a store.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - If either enable is high, capture the request and go to BEAT0.
  - `stall` = read_en | write_en (combinational, same cycle).
- BEAT0:
  - mem_req = 1, mem_addr = address[63:3].
  - mem_byte_en = (2^size − 1) << offset, truncated to 8 bits.
  - mem_wdata = store_data << 8·offset.
  - On `mem_ready`: go to BEAT1 if split, else DONE. `stall` = 1.
- BEAT1:
  - mem_addr = address[63:3] + 1, wrapping modulo 2^MEM_ADDR_WIDTH.
  - mem_byte_en = (2^size − 1) >> (8 − offset).
  - mem_wdata = store_data >> 8·(8 − offset).
  - On `mem_ready`: go to DONE. `stall` = 1.
- DONE:
  - `stall` = 0. The core advances PC at this edge.
  - Enables are ignored here because they belong to the completed instruction. Next state is IDLE.
- Request fields (`mem_req`/`we`/`addr`/`byte_en`/`wdata`) are registered and held stable until `mem_ready`. `mem_req` drops on the cycle after `mem_ready`.
- Load assembly:
  - raw = (beat0 rdata >> 8·offset) | (beat1 rdata << 8·(8 − offset)); the beat1 term is used only when split.
  - Mask raw to size, then extend per funct3.
  - `load_data` is registered on entry to DONE and held until the next load completes. Stores never change it.
- Latency: aligned access with immediate `mem_ready` → request cycle + BEAT0 = 2 stall cycles, with DONE on the 3rd cycle. A split access adds one beat. Each cycle `mem_ready` is late adds one cycle.
- `mem_ready` outside BEAT0/BEAT1 is ignored.
- Reset mid-access: immediate return to IDLE and `mem_req` drops. A beat0 store already written is not rolled back.

Test Plan:
- LD at address 0x1000, `mem_ready` in first BEAT0 cycle, rdata 0x8877665544332211 → `mem_addr` 0x200, byte_en 0xFF, `load_data` 0x8877665544332211, `stall` high for exactly 2 cycles.
- LB at 0x1003, rdata byte3 = 0x80 → byte_en 0x08, `load_data` 0xFFFFFFFFFFFFFF80. LBU with the same stimulus → 0x0000000000000080.
- SW at 0x1006, store_data 0xDEADBEEF:
  - beat0: addr 0x200, byte_en 0xC0, wdata 0xBEEF000000000000.
  - beat1: addr 0x201, byte_en 0x03, wdata 0x000000000000DEAD.
  - `mem_we` = 1 in both beats; `load_data` unchanged.
- LH at 0x1007, beat0 rdata byte7 = 0x34, beat1 rdata byte0 = 0x92 → `load_data` 0xFFFFFFFFFFFF9234, 3 stall cycles.
- LW aligned with `mem_ready` delayed 3 cycles → request fields constant throughout, `stall` held 5 cycles, DONE exactly one cycle. Enables still high in DONE do not start a new access.
- `reset_n` pulled low during BEAT1 of a split load → `mem_req` 0 and `stall` 0 immediately, `load_data` 0. After release, a fresh LD completes normally.

Source files
------------

// File: rtl/data_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_access_unit
// Description : Memory-side responder for the core's load/store enables.
//               Converts one load/store request into one or two aligned
//               64-bit beats on a req/ready data-memory port, splitting
//               accesses that straddle a doubleword boundary, and returns
//               sign/zero-extended load data. Holds the core via `stall`
//               until the access completes.
// Ports       :
//   clock, reset_n         - rising-edge clock, async active-low reset
//   data_mem_read_en       - load request
//   data_mem_write_en      - store request (wins if both are high)
//   inst_funct3            - RV64I access size/sign encoding
//   address, store_data    - byte address and LSB-justified store data
//   load_data              - extended load result (held until next load)
//   stall                  - high while the access is pending
//   mem_req/we/addr/byte_en/wdata - registered memory request fields
//   mem_ready, mem_rdata   - completion pulse and read data
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_access_unit #(
    parameter int MEM_ADDR_WIDTH = 61
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      data_mem_read_en,
    input  logic                      data_mem_write_en,
    input  logic [2:0]                inst_funct3,
    input  logic [63:0]               address,
    input  logic [63:0]               store_data,
    output logic [63:0]               load_data,
    output logic                      stall,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]                mem_byte_en,
    output logic [63:0]               mem_wdata,
    input  logic                      mem_ready,
    input  logic [63:0]               mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [2:0]    r_funct3;
    logic [2:0]    r_offset;
    logic          r_split;
    logic [7:0]    r_be_hi;
    logic [63:0]   r_wdata_hi;
    logic [63:0]   r_rdata0;

    logic [3:0]    w_size_bytes;
    logic [7:0]    w_size_mask;
    logic          w_split;
    logic [15:0]   w_be_wide;
    logic [127:0]  w_wdata_wide;
    logic [63:0]   w_rd0;
    logic [63:0]   w_rd1;
    logic [5:0]    w_shift;
    logic [63:0]   w_raw;
    logic [63:0]   w_load_ext;
    logic          w_any_en;

    assign w_any_en     = data_mem_read_en | data_mem_write_en;
    assign w_size_bytes = 4'd1 << inst_funct3[1:0];
    assign w_split      = ({1'b0, address[2:0]} + w_size_bytes) > 4'd8;

    always_comb begin
        w_size_mask = 8'hFF;
        case (inst_funct3[1:0])
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            2'b10:   w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    // Shifting into a double-width vector yields both beats at once:
    // the low half is beat0, the bits pushed past lane 7 form beat1.
    assign w_be_wide    = {8'h00, w_size_mask} << address[2:0];
    assign w_wdata_wide = {64'd0, store_data} << {address[2:0], 3'b000};

    // In BEAT1 the first doubleword comes from the capture register and the
    // second from the bus; in BEAT0 only the bus word contributes.
    assign w_rd0   = (r_state == BEAT1) ? r_rdata0 : mem_rdata;
    assign w_rd1   = (r_state == BEAT1) ? mem_rdata : 64'd0;
    assign w_shift = {r_offset, 3'b000};
    assign w_raw   = (w_rd0 >> w_shift) | (w_rd1 << (7'd64 - {1'b0, w_shift}));

    always_comb begin
        w_load_ext = w_raw;
        case (r_funct3)
            3'b000:  w_load_ext = {{56{w_raw[7]}},  w_raw[7:0]};
            3'b001:  w_load_ext = {{48{w_raw[15]}}, w_raw[15:0]};
            3'b010:  w_load_ext = {{32{w_raw[31]}}, w_raw[31:0]};
            3'b100:  w_load_ext = {56'd0, w_raw[7:0]};
            3'b101:  w_load_ext = {48'd0, w_raw[15:0]};
            3'b110:  w_load_ext = {32'd0, w_raw[31:0]};
            default: w_load_ext = w_raw;
        endcase
    end

    // Stall is raised combinationally in the request cycle so the PC never
    // advances past an access that has not been accepted yet.
    assign stall = reset_n & ((r_state == IDLE) ? w_any_en
                                                : ((r_state == BEAT0) || (r_state == BEAT1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_funct3    <= 3'd0;
            r_offset    <= 3'd0;
            r_split     <= 1'b0;
            r_be_hi     <= 8'd0;
            r_wdata_hi  <= 64'd0;
            r_rdata0    <= 64'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_byte_en <= 8'd0;
            mem_wdata   <= 64'd0;
            load_data   <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_en) begin
                        r_state     <= BEAT0;
                        r_funct3    <= inst_funct3;
                        r_offset    <= address[2:0];
                        r_split     <= w_split;
                        r_be_hi     <= w_be_wide[15:8];
                        r_wdata_hi  <= w_wdata_wide[127:64];
                        mem_req     <= 1'b1;
                        mem_we      <= data_mem_write_en;
                        mem_addr    <= address[3 +: MEM_ADDR_WIDTH];
                        mem_byte_en <= w_be_wide[7:0];
                        mem_wdata   <= w_wdata_wide[63:0];
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        r_rdata0 <= mem_rdata;
                        if (r_split) begin
                            r_state     <= BEAT1;
                            mem_addr    <= mem_addr + MEM_ADDR_WIDTH'(1);
                            mem_byte_en <= r_be_hi;
                            mem_wdata   <= r_wdata_hi;
                        end else begin
                            r_state <= DONE;
                            mem_req <= 1'b0;
                            if (!mem_we) begin
                                load_data <= w_load_ext;
                            end
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        r_state <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            load_data <= w_load_ext;
                        end
                    end
                end
                default: begin
                    // DONE: enables still belong to the finished instruction.
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_access_unit
// Description : Self-checking bench for data_mem_access_unit. Expected beats
//               and load results are derived byte-by-byte from the access
//               address and size.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_access_unit;

    logic        clock;
    logic        reset_n;
    logic        data_mem_read_en;
    logic        data_mem_write_en;
    logic [2:0]  inst_funct3;
    logic [63:0] address;
    logic [63:0] store_data;
    logic [63:0] load_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [60:0] mem_addr;
    logic [7:0]  mem_byte_en;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    int          n_cmp;
    int          n_fail;
    logic [63:0] exp_load;

    data_mem_access_unit #(.MEM_ADDR_WIDTH(61)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .data_mem_read_en  (data_mem_read_en),
        .data_mem_write_en (data_mem_write_en),
        .inst_funct3       (inst_funct3),
        .address           (address),
        .store_data        (store_data),
        .load_data         (load_data),
        .stall             (stall),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_byte_en       (mem_byte_en),
        .mem_wdata         (mem_wdata),
        .mem_ready         (mem_ready),
        .mem_rdata         (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One complete access: request cycle, beats with the given ready delays,
    // the DONE cycle (enables still asserted), then one idle cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [63:0] a, input logic [63:0] sd,
                              input logic [63:0] r0, input logic [63:0] r1,
                              input int l0, input int l1);
        int          size;
        int          off;
        int          nb;
        int          p;
        int          lat [2];
        logic [7:0]  be [2];
        logic [63:0] wd [2];
        logic [63:0] rdat [2];
        logic [60:0] dw [2];
        logic [63:0] raw;
        logic        signed_ld;

        size    = 1 << f3[1:0];
        off     = int'(a[2:0]);
        nb      = (off + size > 8) ? 2 : 1;
        dw[0]   = a[63:3];
        dw[1]   = a[63:3] + 61'd1;
        rdat[0] = r0;
        rdat[1] = r1;
        lat[0]  = l0;
        lat[1]  = l1;
        be[0]   = 8'd0;
        be[1]   = 8'd0;
        wd[0]   = 64'd0;
        wd[1]   = 64'd0;
        raw     = 64'd0;
        for (int i = 0; i < 8; i++) begin
            p = off + i;
            if (p < 8) wd[0][p*8 +: 8] = sd[i*8 +: 8];
            else       wd[1][(p-8)*8 +: 8] = sd[i*8 +: 8];
            if (i < size) begin
                if (p < 8) begin
                    be[0][p] = 1'b1;
                    raw[i*8 +: 8] = r0[p*8 +: 8];
                end else begin
                    be[1][p-8] = 1'b1;
                    raw[i*8 +: 8] = r1[(p-8)*8 +: 8];
                end
            end
        end
        if (!wr) begin
            signed_ld = (f3[2] == 1'b0) || (f3 == 3'b111);
            if (signed_ld && size < 8 && raw[size*8-1]) begin
                for (int i = size; i < 8; i++) raw[i*8 +: 8] = 8'hFF;
            end
            exp_load = raw;
        end

        @(posedge clock); #1;
        mem_ready         = 1'b0;
        data_mem_read_en  = rd;
        data_mem_write_en = wr;
        inst_funct3       = f3;
        address           = a;
        store_data        = sd;
        @(negedge clock);
        chk("stall_request", {63'd0, stall}, 64'd1);

        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k <= lat[b]; k++) begin
                @(posedge clock); #1;
                mem_ready = (k == lat[b]);
                mem_rdata = (k == lat[b]) ? rdat[b] : rnd64();
                @(negedge clock);
                chk("beat_req",   {63'd0, mem_req}, 64'd1);
                chk("beat_we",    {63'd0, mem_we}, {63'd0, wr});
                chk("beat_addr",  {3'd0, mem_addr}, {3'd0, dw[b]});
                chk("beat_be",    {56'd0, mem_byte_en}, {56'd0, be[b]});
                if (wr) chk("beat_wdata", mem_wdata, wd[b]);
                chk("beat_stall", {63'd0, stall}, 64'd1);
            end
        end

        @(posedge clock); #1;
        mem_ready = $urandom_range(0, 1) == 1;
        mem_rdata = rnd64();
        @(negedge clock);
        chk("done_stall", {63'd0, stall}, 64'd0);
        chk("done_req",   {63'd0, mem_req}, 64'd0);
        chk("done_load",  load_data, exp_load);

        @(posedge clock); #1;
        data_mem_read_en  = 1'b0;
        data_mem_write_en = 1'b0;
        mem_ready         = $urandom_range(0, 1) == 1;
        mem_rdata         = rnd64();
        @(negedge clock);
        chk("idle_req",   {63'd0, mem_req}, 64'd0);
        chk("idle_stall", {63'd0, stall}, 64'd0);
        chk("idle_load",  load_data, exp_load);
    endtask

    initial begin
        logic        rd;
        logic        wr;
        n_cmp             = 0;
        n_fail            = 0;
        exp_load          = 64'd0;
        reset_n           = 1'b0;
        data_mem_read_en  = 1'b1;
        data_mem_write_en = 1'b0;
        inst_funct3       = 3'b011;
        address           = 64'h1000;
        store_data        = 64'd0;
        mem_ready         = 1'b0;
        mem_rdata         = 64'd0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_stall",   {63'd0, stall}, 64'd0);
        chk("rst_req",     {63'd0, mem_req}, 64'd0);
        chk("rst_we",      {63'd0, mem_we}, 64'd0);
        chk("rst_addr",    {3'd0, mem_addr}, 64'd0);
        chk("rst_be",      {56'd0, mem_byte_en}, 64'd0);
        chk("rst_wdata",   mem_wdata, 64'd0);
        chk("rst_load",    load_data, 64'd0);
        data_mem_read_en = 1'b0;
        reset_n          = 1'b1;

        // Directed cases
        run_access(1, 0, 3'b011, 64'h1000, 64'd0, 64'h8877665544332211, 64'd0, 0, 0);
        chk("ld_value", load_data, 64'h8877665544332211);
        run_access(1, 0, 3'b000, 64'h1003, 64'd0, 64'h1122334480556677, 64'd0, 0, 0);
        chk("lb_value", load_data, 64'hFFFFFFFFFFFFFF80);
        run_access(1, 0, 3'b100, 64'h1003, 64'd0, 64'h1122334480556677, 64'd0, 0, 0);
        chk("lbu_value", load_data, 64'h0000000000000080);
        run_access(0, 1, 3'b010, 64'h1006, 64'hDEADBEEF, rnd64(), rnd64(), 0, 0);
        chk("sw_keeps_load", load_data, 64'h0000000000000080);
        run_access(1, 0, 3'b001, 64'h1007, 64'd0, 64'h34AABBCCDDEEFF00, 64'h0123456789ABCD92, 0, 0);
        chk("lh_split_value", load_data, 64'hFFFFFFFFFFFF9234);
        run_access(1, 0, 3'b010, 64'h2000, 64'd0, 64'h13579BDF80A0B0C0, 64'd0, 3, 0);
        chk("lw_delay_value", load_data, 64'hFFFFFFFF80A0B0C0);
        run_access(1, 0, 3'b111, 64'hFFFFFFFFFFFFFFFC, 64'd0, rnd64(), rnd64(), 1, 1);
        run_access(1, 1, 3'b011, 64'h3003, rnd64(), rnd64(), rnd64(), 0, 2);

        // Reset during BEAT1 of a split load
        @(posedge clock); #1;
        mem_ready         = 1'b0;
        data_mem_read_en  = 1'b1;
        data_mem_write_en = 1'b0;
        inst_funct3       = 3'b011;
        address           = 64'h2005;
        @(posedge clock); #1;
        mem_ready = 1'b1;
        mem_rdata = rnd64();
        @(posedge clock); #1;
        mem_ready = 1'b0;
        @(negedge clock);
        chk("mid_beat1_req",  {63'd0, mem_req}, 64'd1);
        chk("mid_beat1_addr", {3'd0, mem_addr}, 64'h401);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req",   {63'd0, mem_req}, 64'd0);
        chk("mid_rst_stall", {63'd0, stall}, 64'd0);
        chk("mid_rst_load",  load_data, 64'd0);
        exp_load = 64'd0;
        @(posedge clock); #1;
        data_mem_read_en = 1'b0;
        reset_n          = 1'b1;
        run_access(1, 0, 3'b011, 64'h4000, 64'd0, 64'hCAFEF00D12345678, 64'd0, 0, 0);
        chk("post_rst_ld", load_data, 64'hCAFEF00D12345678);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            rd = $urandom_range(0, 1) == 1;
            wr = $urandom_range(0, 1) == 1;
            if (!rd && !wr) rd = 1'b1;
            run_access(rd, wr, 3'($urandom_range(0, 7)), rnd64(), rnd64(), rnd64(), rnd64(),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
